// File: rtl/w_loader.sv
// ---------------------------------------------------------------------------
// w_loader
//
// Write side of the runtime weight store. A host streams fixed-point weight
// words over a valid/ready handshake. The words land in four registered,
// flattened weight buses: generator layers 2/3 (wg2, wg3) and discriminator
// layers 2/3 (wd2, wd3). The bus layout is the one the layer datapaths
// already consume. Only the sections named in sec_mask are rewritten. All
// other sections keep their contents.
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   one-cycle load request, sampled only while idle
//   sec_mask  in   sections to load: bit0 wg2, bit1 wg3, bit2 wd2, bit3 wd3
//   s_valid   in   s_data carries a weight word
//   s_data    in   weight word, stored bit-exact
//   s_ready   out  a word is accepted this cycle when s_valid is high
//   busy      out  a load is in progress
//   done      out  one-cycle pulse when a load (or an empty request) ends
//   loaded    out  per-section "contents complete" flags, sec_mask order
//   wg2/wg3   out  generator weight buses, word k at [k*WIDTH +: WIDTH]
//   wd2/wd3   out  discriminator weight buses, same layout
// ---------------------------------------------------------------------------
module w_loader #(
   parameter int WIDTH   = 32,
   parameter int N_INPUT = 2,
   parameter int N_G_L2  = 3,
   parameter int N_G_L3  = 9,
   parameter int N_D_L2  = 3,
   parameter int N_D_L3  = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [3:0]                        sec_mask,
   input  logic                              s_valid,
   input  logic [WIDTH-1:0]                  s_data,
   output logic                              s_ready,
   output logic                              busy,
   output logic                              done,
   output logic [3:0]                        loaded,
   output logic [N_INPUT*N_G_L2*WIDTH-1:0]   wg2,
   output logic [N_G_L2*N_G_L3*WIDTH-1:0]    wg3,
   output logic [N_G_L3*N_D_L2*WIDTH-1:0]    wd2,
   output logic [N_D_L2*N_D_L3*WIDTH-1:0]    wd3
);

   // Section sizes in words. The counter is wide enough for the largest
   // section and never narrower than 5 bits.
   localparam int SZ_WG2 = N_INPUT * N_G_L2;
   localparam int SZ_WG3 = N_G_L2 * N_G_L3;
   localparam int SZ_WD2 = N_G_L3 * N_D_L2;
   localparam int SZ_WD3 = N_D_L2 * N_D_L3;
   localparam int MAX_A  = (SZ_WG2 > SZ_WG3) ? SZ_WG2 : SZ_WG3;
   localparam int MAX_B  = (SZ_WD2 > SZ_WD3) ? SZ_WD2 : SZ_WD3;
   localparam int MAX_SZ = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W  = ($clog2(MAX_SZ) > 5) ? $clog2(MAX_SZ) : 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                             state_q, state_d;
   logic [3:0]                         mask_q, mask_d;
   logic [1:0]                         sec_q, sec_d;
   logic [CNT_W-1:0]                   cnt_q, cnt_d;
   logic [3:0]                         loaded_q, loaded_d;
   logic                               done_q, done_d;
   logic [N_INPUT*N_G_L2*WIDTH-1:0]    wg2_q, wg2_d;
   logic [N_G_L2*N_G_L3*WIDTH-1:0]     wg3_q, wg3_d;
   logic [N_G_L3*N_D_L2*WIDTH-1:0]     wd2_q, wd2_d;
   logic [N_D_L2*N_D_L3*WIDTH-1:0]     wd3_q, wd3_d;

   logic                               hs;
   logic                               last_word;
   logic [1:0]                         first_sec;
   logic [1:0]                         next_sec;
   logic                               has_next;

   // Index of the final word of a section, as a counter value.
   function automatic logic [CNT_W-1:0] sec_last(input logic [1:0] s);
      logic [CNT_W-1:0] r;
      case (s)
         2'd0:    r = CNT_W'(SZ_WG2 - 1);
         2'd1:    r = CNT_W'(SZ_WG3 - 1);
         2'd2:    r = CNT_W'(SZ_WD2 - 1);
         default: r = CNT_W'(SZ_WD3 - 1);
      endcase
      return r;
   endfunction

   assign hs        = s_valid && (state_q == ST_LOAD);
   assign last_word = (cnt_q == sec_last(sec_q));

   // Section selection. The first section is the lowest bit set in the
   // incoming mask. The next section is the lowest enabled bit above the one
   // being written. Both loops scan downwards, so the lowest match is the
   // one that sticks.
   always_comb begin
      first_sec = 2'd0;
      next_sec  = 2'd0;
      has_next  = 1'b0;
      for (int s = 3; s >= 0; s--) begin
         if (sec_mask[s]) begin
            first_sec = 2'(s);
         end
         if (mask_q[s] && (s > int'(sec_q))) begin
            next_sec = 2'(s);
            has_next = 1'b1;
         end
      end
   end

   // Next-state logic. Every register holds by default. A handshake writes
   // the word into the slot the counter points at in the active section.
   // Sections change with no idle cycle in between. A section's loaded flag
   // drops on the edge its load begins. The flag rises again on the edge
   // that accepts its final word.
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      sec_d    = sec_q;
      cnt_d    = cnt_q;
      loaded_d = loaded_q;
      done_d   = 1'b0;
      wg2_d    = wg2_q;
      wg3_d    = wg3_q;
      wd2_d    = wd2_q;
      wd3_d    = wd3_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (sec_mask != 4'b0000) begin
                  mask_d              = sec_mask;
                  sec_d               = first_sec;
                  cnt_d               = '0;
                  loaded_d[first_sec] = 1'b0;
                  state_d             = ST_LOAD;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         ST_LOAD: begin
            if (hs) begin
               case (sec_q)
                  2'd0: begin
                     for (int k = 0; k < SZ_WG2; k++) begin
                        if (cnt_q == CNT_W'(k)) wg2_d[k*WIDTH +: WIDTH] = s_data;
                     end
                  end
                  2'd1: begin
                     for (int k = 0; k < SZ_WG3; k++) begin
                        if (cnt_q == CNT_W'(k)) wg3_d[k*WIDTH +: WIDTH] = s_data;
                     end
                  end
                  2'd2: begin
                     for (int k = 0; k < SZ_WD2; k++) begin
                        if (cnt_q == CNT_W'(k)) wd2_d[k*WIDTH +: WIDTH] = s_data;
                     end
                  end
                  default: begin
                     for (int k = 0; k < SZ_WD3; k++) begin
                        if (cnt_q == CNT_W'(k)) wd3_d[k*WIDTH +: WIDTH] = s_data;
                     end
                  end
               endcase

               if (last_word) begin
                  loaded_d[sec_q] = 1'b1;
                  cnt_d           = '0;
                  if (has_next) begin
                     sec_d              = next_sec;
                     loaded_d[next_sec] = 1'b0;
                  end else begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register. Reset wipes everything, including weights that were
   // already written. An interrupted load therefore never looks partly valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mask_q   <= '0;
         sec_q    <= '0;
         cnt_q    <= '0;
         loaded_q <= '0;
         done_q   <= 1'b0;
         wg2_q    <= '0;
         wg3_q    <= '0;
         wd2_q    <= '0;
         wd3_q    <= '0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         sec_q    <= sec_d;
         cnt_q    <= cnt_d;
         loaded_q <= loaded_d;
         done_q   <= done_d;
         wg2_q    <= wg2_d;
         wg3_q    <= wg3_d;
         wd2_q    <= wd2_d;
         wd3_q    <= wd3_d;
      end
   end

   // Handshake and status outputs follow the state register directly. The
   // done flop covers both a completed load and an empty-mask request.
   always_comb begin
      s_ready = (state_q == ST_LOAD);
      busy    = (state_q == ST_LOAD);
      done    = done_q;
      loaded  = loaded_q;
      wg2     = wg2_q;
      wg3     = wg3_q;
      wd2     = wd2_q;
      wd3     = wd3_q;
   end

endmodule
